star_norm_div: RTL and testbench



---
 rtl/star_norm_div_pkg.sv | 18 +
 rtl/star_seq_div.sv | 58 +++++
 rtl/star_norm_div.sv | 137 +++++++++++++
 tb/tb_star_norm_div.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/star_norm_div_pkg.sv
// Shared constants and state encoding for the STAR softmax
// normalisation stage.
package star_norm_div_pkg;

   localparam int STAR_INPUT_LEN = 16;
   localparam int STAR_N_ELEM    = STAR_INPUT_LEN;
   localparam int STAR_EXP_W     = 32;
   localparam int STAR_FRAC      = 15;
   localparam int STAR_OUT_W     = STAR_FRAC + 1;
   localparam int STAR_SUM_W     = STAR_EXP_W + $clog2(STAR_N_ELEM);

   typedef enum logic [1:0] {
      ACCUM,
      DIV,
      HOLD
   } star_norm_state_e;

endpackage

// File: rtl/star_seq_div.sv
// Bit-serial restoring divider producing Q_W quotient bits MSB first.
// Caller guarantees dividend <= divisor and divisor != 0.
module star_seq_div
   import star_norm_div_pkg::*;
#(
   parameter int DIV_W = STAR_SUM_W,
   parameter int Q_W   = STAR_OUT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic             done,
   output logic [Q_W-1:0]   quotient
);

   localparam int REM_W = DIV_W + 1;
   localparam int CW    = $clog2(Q_W);

   logic [REM_W-1:0] rem;
   logic [REM_W-1:0] rem_in;
   logic [REM_W-1:0] rem_nxt;
   logic             q_bit;
   logic [CW-1:0]    cnt;
   logic             active;

   // start folds the load into the first iteration
   always_comb begin
      rem_in  = start ? {1'b0, dividend} : rem;
      q_bit   = rem_in >= {1'b0, divisor};
      rem_nxt = q_bit ? (rem_in - {1'b0, divisor}) : rem_in;
      rem_nxt = rem_nxt << 1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem      <= '0;
         quotient <= '0;
         cnt      <= '0;
         active   <= 1'b0;
      end else if (start) begin
         rem      <= rem_nxt;
         quotient <= {{(Q_W-1){1'b0}}, q_bit};
         cnt      <= CW'(Q_W - 1);
         active   <= 1'b1;
      end else if (active && cnt != '0) begin
         rem      <= rem_nxt;
         quotient <= {quotient[Q_W-2:0], q_bit};
         cnt      <= cnt - 1'b1;
      end else begin
         active   <= 1'b0;
      end
   end

   assign done = active && (cnt == '0);

endmodule

// File: rtl/star_norm_div.sv
// Softmax normalisation: buffers one row of exp values, sums them,
// then emits each exp/sum as a Q1.15 probability.
module star_norm_div
   import star_norm_div_pkg::*;
#(
   parameter int N_ELEM = STAR_N_ELEM,
   parameter int EXP_W  = STAR_EXP_W,
   parameter int FRAC   = STAR_FRAC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [EXP_W-1:0] in_exp,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FRAC:0]    out_result,
   output logic             out_last,
   output logic             busy,
   output logic             div_zero
);

   localparam int OUT_W = FRAC + 1;
   localparam int SUM_W = EXP_W + $clog2(N_ELEM);
   localparam int IDX_W = $clog2(N_ELEM);
   localparam int CNT_W = $clog2(N_ELEM + 1);

   star_norm_state_e state;

   logic [EXP_W-1:0] row_buf [N_ELEM];
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] n;
   logic [IDX_W-1:0] k;
   logic             started;
   logic             accept;
   logic             row_end;
   logic             last_k;
   logic             div_start;
   logic             div_done;
   logic [OUT_W-1:0] div_q;

   assign accept    = in_valid && in_ready;
   assign row_end   = in_last || (cnt == CNT_W'(N_ELEM - 1));
   assign last_k    = CNT_W'(k) == (n - CNT_W'(1));
   assign div_start = (state == DIV) && !started && (sum != '0);
   assign busy      = (state != ACCUM) || (cnt != '0);

   star_seq_div #(
      .DIV_W (SUM_W),
      .Q_W   (OUT_W)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (SUM_W'(row_buf[k])),
      .divisor  (sum),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge clk) begin
      if (accept)
         row_buf[cnt[IDX_W-1:0]] <= in_exp;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ACCUM;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_last   <= 1'b0;
         div_zero   <= 1'b0;
         sum        <= '0;
         cnt        <= '0;
         n          <= '0;
         k          <= '0;
         started    <= 1'b0;
      end else begin
         unique case (state)
            ACCUM: begin
               if (accept) begin
                  sum <= sum + SUM_W'(in_exp);
                  cnt <= cnt + 1'b1;
                  if (cnt == '0)
                     div_zero <= 1'b0;
                  if (row_end) begin
                     state    <= DIV;
                     in_ready <= 1'b0;
                     n        <= cnt + 1'b1;
                     k        <= '0;
                     started  <= 1'b0;
                  end
               end
            end
            DIV: begin
               // an all-zero row has no meaningful ratio; report 0
               if (sum == '0) begin
                  state      <= HOLD;
                  out_valid  <= 1'b1;
                  out_result <= '0;
                  out_last   <= last_k;
                  div_zero   <= 1'b1;
               end else begin
                  if (div_start)
                     started <= 1'b1;
                  if (started && div_done) begin
                     state      <= HOLD;
                     out_valid  <= 1'b1;
                     out_result <= div_q;
                     out_last   <= last_k;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     state    <= ACCUM;
                     sum      <= '0;
                     cnt      <= '0;
                     in_ready <= 1'b1;
                  end else begin
                     state   <= DIV;
                     k       <= k + 1'b1;
                     started <= 1'b0;
                  end
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_star_norm_div.sv
// Self-checking bench for star_norm_div: spec vectors, corner
// sequences and random rows against an arithmetic reference.
module tb_star_norm_div;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_exp;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_last;
   logic        busy;
   logic        div_zero;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   star_norm_div dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_exp     (in_exp),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_last   (out_last),
      .busy       (busy),
      .div_zero   (div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               n;
      logic             use_last;
      int               hold;
      logic [15:0][31:0] v;
      logic [15:0][15:0] q;
      logic             dz;
   } vec_t;

   vec_t tbl [5];

   function automatic logic [15:0] ref_q(input longint unsigned v,
                                         input longint unsigned s);
      longint unsigned r;
      if (s == 0) return 16'h0;
      r = (v * 64'd32768) / s;
      return r[15:0];
   endfunction

   task automatic check(input string name,
                        input longint unsigned act,
                        input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push(input logic [31:0] v, input logic last);
      int w = 0;
      in_valid = 1'b1;
      in_exp   = v;
      in_last  = last;
      while (!in_ready && w < 200) begin
         step();
         w++;
      end
      check("in_ready_wait", in_ready, 1);
      if (in_ready) step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pull(input string name, input logic [15:0] eq,
                       input logic el, input int hold, input int elat);
      int w = 0;
      int s;
      s = cyc;
      out_ready = 1'b0;
      while (!out_valid && w < 300) begin
         step();
         w++;
      end
      check({name, "_valid"}, out_valid, 1);
      if (out_valid) begin
         if (elat >= 0) check({name, "_lat"}, cyc - s, elat);
         check({name, "_res"}, out_result, eq);
         check({name, "_last"}, out_last, el);
         for (int i = 0; i < hold; i++) begin
            step();
            check({name, "_hold_valid"}, out_valid, 1);
            check({name, "_hold_res"}, out_result, eq);
            check({name, "_hold_last"}, out_last, el);
         end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask

   task automatic run_row(input string name, input logic [31:0] v[$],
                          input logic [15:0] q[$], input logic dz,
                          input logic use_last, input int hold);
      int n;
      bit nz;
      n  = v.size();
      nz = 0;
      foreach (v[i]) if (v[i] != 0) nz = 1;
      for (int i = 0; i < n; i++) begin
         push(v[i], use_last && (i == n - 1));
         if (i == 0) check({name, "_dz_clr"}, div_zero, 0);
         if (i == 0 && n > 1) check({name, "_busy_part"}, busy, 1);
      end
      check({name, "_rdy_div"}, in_ready, 0);
      for (int i = 0; i < n; i++)
         pull($sformatf("%s_e%0d", name, i), q[i], i == n - 1,
              hold, nz ? 17 : -1);
      check({name, "_dz"}, div_zero, dz);
      check({name, "_rdy_end"}, in_ready, 1);
      check({name, "_busy_end"}, busy, 0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] vq[$];
      logic [15:0] qq[$];
      longint unsigned s;
      int n, mode, hold;
      logic ul;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_exp    = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_div_zero", div_zero, 0);

      for (int i = 0; i < 5; i++) tbl[i] = '{default: 0};
      tbl[0].n = 4; tbl[0].use_last = 1;
      for (int i = 0; i < 4; i++) begin
         tbl[0].v[i] = 32'd100;
         tbl[0].q[i] = 16'h2000;
      end
      tbl[1].n = 2; tbl[1].use_last = 1; tbl[1].hold = 5;
      tbl[1].v[0] = 32'd1; tbl[1].q[0] = 16'h2000;
      tbl[1].v[1] = 32'd3; tbl[1].q[1] = 16'h6000;
      tbl[2].n = 1; tbl[2].use_last = 1;
      tbl[2].v[0] = 32'd12345; tbl[2].q[0] = 16'h8000;
      tbl[3].n = 3; tbl[3].use_last = 1; tbl[3].dz = 1;
      tbl[4].n = 2; tbl[4].use_last = 1;
      tbl[4].v[0] = 32'd0; tbl[4].q[0] = 16'h0000;
      tbl[4].v[1] = 32'd9; tbl[4].q[1] = 16'h8000;

      for (int t = 0; t < 5; t++) begin
         vq.delete();
         qq.delete();
         for (int i = 0; i < tbl[t].n; i++) begin
            vq.push_back(tbl[t].v[i]);
            qq.push_back(tbl[t].q[i]);
         end
         run_row($sformatf("tbl%0d", t), vq, qq, tbl[t].dz,
                 tbl[t].use_last, tbl[t].hold);
      end

      // 17 ones without in_last; the 17th waits with in_valid held
      for (int i = 0; i < 16; i++) push(32'd1, 1'b0);
      check("split_rdy_div", in_ready, 0);
      check("split_busy", busy, 1);
      in_valid = 1'b1;
      in_exp   = 32'd1;
      in_last  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pull($sformatf("split_e%0d", i), 16'h0800, i == 15, 0, 17);
         if (i == 7) check("split_rdy_hold", in_ready, 0);
      end
      push(32'd1, 1'b1);
      pull("split_next", 16'h8000, 1'b1, 0, 17);

      // reset in the middle of dividing element 2
      push(32'd5, 1'b0);
      push(32'd7, 1'b0);
      push(32'd9, 1'b1);
      pull("rstmid_e0", ref_q(5, 21), 1'b0, 0, 17);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstmid_in_ready", in_ready, 1);
      check("rstmid_out_valid", out_valid, 0);
      check("rstmid_out_result", out_result, 0);
      check("rstmid_out_last", out_last, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_div_zero", div_zero, 0);
      vq = '{32'd2, 32'd2};
      qq = '{16'h4000, 16'h4000};
      run_row("after_rst", vq, qq, 1'b0, 1'b1, 0);

      for (int r = 0; r < 40; r++) begin
         n    = $urandom_range(1, 16);
         mode = $urandom_range(0, 7);
         hold = $urandom_range(0, 2);
         ul   = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         vq.delete();
         qq.delete();
         s = 0;
         for (int i = 0; i < n; i++) begin
            if (mode == 0) vq.push_back(32'd0);
            else if (mode == 1) vq.push_back($urandom_range(0, 3));
            else vq.push_back($urandom);
            s += longint'(vq[i]);
         end
         foreach (vq[i]) qq.push_back(ref_q(vq[i], s));
         run_row($sformatf("rnd%0d", r), vq, qq, s == 0, ul, hold);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
